// File: rtl/minutes_hours.sv
// minutes_hours: minutes and hours stage of the real-time clock chain.
// It advances on the seconds-stage terminal-count pulse. It shares the
// load/addrs/data_in programming bus with the seconds stage, so the whole
// time of day is set over one 6-bit bus.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous, active-low reset
//   tc_seconds  one-clock pulse when seconds wraps 59->0
//   load        programming strobe
//   addrs       register select: 01 minutes, 10 hours, 00/11 ignored
//   data_in     load value
//   q_minutes   current minutes
//   q_hours     current hours (0..23, or 1..12 in 12-hour mode)
//   pm          PM flag in 12-hour mode, 0 in 24-hour mode
//   tc_minutes  one-clock pulse when minutes wraps to 0
//   tc_day      one-clock pulse on day rollover
module minutes_hours #(
    parameter int HOUR_MODE_24 = 1,
    parameter int MAX_MINUTES  = 59
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tc_seconds,
    input  logic       load,
    input  logic [1:0] addrs,
    input  logic [5:0] data_in,
    output logic [5:0] q_minutes,
    output logic [4:0] q_hours,
    output logic       pm,
    output logic       tc_minutes,
    output logic       tc_day
);

    localparam logic [5:0] MAX_MIN = 6'(MAX_MINUTES);
    localparam logic       MODE_24 = (HOUR_MODE_24 != 0);
    // 12-hour mode resets to 12:00 AM, which is hour 0 in 24-hour terms.
    localparam logic [4:0] HR_RST  = MODE_24 ? 5'd0 : 5'd12;

    logic       min_load_ok;
    logic       hr_load_ok;
    logic       carry;
    logic [5:0] min_nxt;
    logic [4:0] hr_nxt;
    logic       pm_nxt;
    logic       tcm_nxt;
    logic       tcd_nxt;

    assign min_load_ok = load && (addrs == 2'b01) && (data_in <= MAX_MIN);

    always_comb begin
        hr_load_ok = 1'b0;
        if (load && (addrs == 2'b10)) begin
            if (MODE_24)
                hr_load_ok = !data_in[5] && (data_in[4:0] <= 5'd23);
            else
                hr_load_ok = !data_in[4] && (data_in[3:0] >= 4'd1)
                             && (data_in[3:0] <= 4'd12);
        end
    end

    always_comb begin
        min_nxt = q_minutes;
        hr_nxt  = q_hours;
        pm_nxt  = pm;
        tcm_nxt = 1'b0;
        tcd_nxt = 1'b0;
        carry   = 1'b0;

        // A valid minutes load takes priority over the count and also
        // suppresses the carry into hours for this cycle.
        if (min_load_ok) begin
            min_nxt = data_in;
        end else if (tc_seconds) begin
            if (q_minutes >= MAX_MIN) begin
                min_nxt = 6'd0;
                tcm_nxt = 1'b1;
                carry   = 1'b1;
            end else begin
                min_nxt = q_minutes + 6'd1;
            end
        end

        // A valid hours load replaces the hours step, so a wrap in the
        // same cycle never produces tc_day.
        if (hr_load_ok) begin
            if (MODE_24) begin
                hr_nxt = data_in[4:0];
                pm_nxt = 1'b0;
            end else begin
                hr_nxt = {1'b0, data_in[3:0]};
                pm_nxt = data_in[5];
            end
        end else if (carry) begin
            if (MODE_24) begin
                if (q_hours >= 5'd23) begin
                    hr_nxt  = 5'd0;
                    tcd_nxt = 1'b1;
                end else begin
                    hr_nxt = q_hours + 5'd1;
                end
            end else begin
                if (q_hours == 5'd11) begin
                    hr_nxt  = 5'd12;
                    pm_nxt  = !pm;
                    // 11 PM -> 12 AM is the start of a new day.
                    tcd_nxt = pm;
                end else if (q_hours >= 5'd12) begin
                    hr_nxt = 5'd1;
                end else begin
                    hr_nxt = q_hours + 5'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_minutes  <= 6'd0;
            q_hours    <= HR_RST;
            pm         <= 1'b0;
            tc_minutes <= 1'b0;
            tc_day     <= 1'b0;
        end else begin
            q_minutes  <= min_nxt;
            q_hours    <= hr_nxt;
            pm         <= MODE_24 ? 1'b0 : pm_nxt;
            tc_minutes <= tcm_nxt;
            tc_day     <= tcd_nxt;
        end
    end

endmodule

// File: tb/tb_minutes_hours.sv
module tb_minutes_hours;

    typedef struct packed {
        logic [5:0] m;
        logic [4:0] h;
        logic       pm;
        logic       tcm;
        logic       tcd;
    } obs_t;

    typedef struct packed {
        obs_t e24;
        obs_t e12;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tc_seconds = 1'b0;
    logic       load = 1'b0;
    logic [1:0] addrs = 2'b00;
    logic [5:0] data_in = 6'd0;

    logic [5:0] m24, m12;
    logic [4:0] h24, h12;
    logic       pm24, pm12, tcm24, tcm12, tcd24, tcd12;

    int compared = 0;
    int mismatched = 0;

    // Reference state: minute of the day, 0..1439, one per DUT.
    int mod24 = 0;
    int mod12 = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    minutes_hours #(.HOUR_MODE_24(1), .MAX_MINUTES(59)) dut24 (
        .clk(clk), .reset(reset), .tc_seconds(tc_seconds), .load(load),
        .addrs(addrs), .data_in(data_in), .q_minutes(m24), .q_hours(h24),
        .pm(pm24), .tc_minutes(tcm24), .tc_day(tcd24)
    );

    minutes_hours #(.HOUR_MODE_24(0), .MAX_MINUTES(59)) dut12 (
        .clk(clk), .reset(reset), .tc_seconds(tc_seconds), .load(load),
        .addrs(addrs), .data_in(data_in), .q_minutes(m12), .q_hours(h12),
        .pm(pm12), .tc_minutes(tcm12), .tc_day(tcd12)
    );

    function automatic obs_t view(int mod, bit mode12, bit tcm, bit tcd);
        obs_t o;
        int h;
        h     = mod / 60;
        o.m   = 6'(mod % 60);
        o.tcm = tcm;
        o.tcd = tcd;
        if (mode12) begin
            o.h  = 5'(((h % 12) == 0) ? 12 : (h % 12));
            o.pm = (h >= 12);
        end else begin
            o.h  = 5'(h);
            o.pm = 1'b0;
        end
        return o;
    endfunction

    // Advance one minute-of-day model by one clock.
    task automatic model_step(inout int mod, input bit mode12, input bit ld,
                              input logic [1:0] a, input logic [5:0] d,
                              input bit tcs, output obs_t o);
        int h, m, nh, nm, hval;
        bit mload, hload, carry, tcm, tcd;
        h = mod / 60;
        m = mod % 60;
        nh = h; nm = m; carry = 0; tcm = 0; tcd = 0;
        mload = ld && (a == 2'b01) && (d <= 6'd59);
        if (mode12) begin
            hload = ld && (a == 2'b10) && !d[4] && (d[3:0] >= 1) && (d[3:0] <= 12);
            hval  = (int'(d[3:0]) % 12) + (d[5] ? 12 : 0);
        end else begin
            hload = ld && (a == 2'b10) && !d[5] && (d[4:0] <= 23);
            hval  = int'(d[4:0]);
        end
        if (mload) nm = int'(d);
        else if (tcs) begin
            if (m == 59) begin nm = 0; tcm = 1; carry = 1; end
            else nm = m + 1;
        end
        if (hload) nh = hval;
        else if (carry) begin
            nh  = (h + 1) % 24;
            tcd = (nh == 0);
        end
        mod = nh * 60 + nm;
        o = view(mod, mode12, tcm, tcd);
    endtask

    task automatic check_obs(string name, obs_t got, obs_t want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s got m=%0d h=%0d pm=%0b tcm=%0b tcd=%0b want m=%0d h=%0d pm=%0b tcm=%0b tcd=%0b t=%0t",
                     name, got.m, got.h, got.pm, got.tcm, got.tcd,
                     want.m, want.h, want.pm, want.tcm, want.tcd, $time);
        end
    endtask

    task automatic drive(bit rst_v, bit ld, logic [1:0] a, logic [5:0] d, bit tcs);
        exp_t e;
        @(negedge clk);
        reset = rst_v; load = ld; addrs = a; data_in = d; tc_seconds = tcs;
        if (!rst_v) begin
            mod24 = 0;
            mod12 = 0;
            e.e24 = view(0, 0, 0, 0);
            e.e12 = view(0, 1, 0, 0);
            sb.push_back(e);
            // Reset must take effect without waiting for a clock edge.
            #1;
            check_obs("async_rst24", {m24, h24, pm24, tcm24, tcd24}, e.e24);
            check_obs("async_rst12", {m12, h12, pm12, tcm12, tcd12}, e.e12);
        end else begin
            model_step(mod24, 0, ld, a, d, tcs, e.e24);
            model_step(mod12, 1, ld, a, d, tcs, e.e12);
            sb.push_back(e);
        end
    endtask

    // Monitor: outputs are registered, so a result is presented every clock.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_obs("mode24", {m24, h24, pm24, tcm24, tcd24}, e.e24);
            check_obs("mode12", {m12, h12, pm12, tcm12, tcd12}, e.e12);
        end
    end

    initial begin
        // Reset low for 3 cycles, then idle hold.
        repeat (3) drive(0, 0, 2'b00, 6'd0, 0);
        repeat (100) drive(1, 0, 2'b00, 6'd0, 0);

        // Minutes 58 -> 59 -> 0 with carry into hours.
        drive(1, 1, 2'b01, 6'd58, 0);
        drive(1, 0, 2'b00, 6'd0, 1);
        drive(1, 0, 2'b00, 6'd0, 1);
        drive(1, 0, 2'b00, 6'd0, 0);

        // 23:59 -> 00:00 day rollover.
        drive(1, 1, 2'b10, 6'd23, 0);
        drive(1, 1, 2'b01, 6'd59, 0);
        drive(1, 0, 2'b00, 6'd0, 1);
        drive(1, 0, 2'b00, 6'd0, 0);

        // Invalid and ignored loads.
        drive(1, 1, 2'b01, 6'd60, 0);
        drive(1, 1, 2'b10, 6'd24, 0);
        drive(1, 1, 2'b00, 6'd5, 0);
        drive(1, 1, 2'b11, 6'd7, 0);

        // Simultaneous load and count.
        drive(1, 1, 2'b10, 6'd5, 0);
        drive(1, 1, 2'b01, 6'd59, 0);
        drive(1, 1, 2'b01, 6'd10, 1);
        drive(1, 1, 2'b01, 6'd59, 0);
        drive(1, 1, 2'b10, 6'd7, 1);
        drive(1, 1, 2'b01, 6'd60, 1);
        drive(1, 0, 2'b00, 6'd0, 0);

        // 11:59 PM -> 12:00 AM in 12-hour mode.
        drive(1, 1, 2'b10, 6'b101011, 0);
        drive(1, 1, 2'b01, 6'd59, 0);
        drive(1, 0, 2'b00, 6'd0, 1);
        drive(1, 0, 2'b00, 6'd0, 0);
        // 11:59 AM -> 12:00 PM, then 12:59 PM -> 1:00 PM.
        drive(1, 1, 2'b10, 6'b001011, 0);
        drive(1, 1, 2'b01, 6'd59, 0);
        drive(1, 0, 2'b00, 6'd0, 1);
        drive(1, 1, 2'b01, 6'd59, 0);
        drive(1, 0, 2'b00, 6'd0, 1);

        // Reset asserted mid-operation, right after a wrap pulse.
        drive(1, 1, 2'b01, 6'd59, 0);
        drive(1, 0, 2'b00, 6'd0, 1);
        drive(0, 0, 2'b00, 6'd0, 1);
        drive(1, 0, 2'b00, 6'd0, 1);

        // Randomized traffic, mostly counting so wraps and rollovers occur.
        for (int i = 0; i < 4000; i++) begin
            bit rst_v, ld, tcs;
            logic [1:0] a;
            logic [5:0] d;
            rst_v = ($urandom_range(0, 299) != 0);
            ld    = ($urandom_range(0, 9) == 0);
            a     = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1)
                d = (a == 2'b01) ? 6'd59 : 6'($urandom_range(10, 12) + ($urandom_range(0, 1) * 32));
            else
                d = 6'($urandom_range(0, 63));
            if (a == 2'b10 && $urandom_range(0, 3) == 0) d = 6'd23;
            tcs = ($urandom_range(0, 3) != 0);
            drive(rst_v, ld, a, d, tcs);
        end

        drive(1, 0, 2'b00, 6'd0, 0);
        repeat (3) @(posedge clk);
        #2;
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/minutes_hours.md
Name: minutes_hours

Overview:
- Downstream stage of the seconds counter in the real-clock chain.
- Consumes the seconds terminal-count pulse and maintains the minutes and hours registers.
- Produces the minutes/hours carry and day-rollover pulses.
- Shares the load/addrs/data_in programming bus with the seconds stage, so the whole time of day is set over one 6-bit bus.

Parameters:
HOUR_MODE_24, 1, 1 = hours count 0..23; 0 = 12-hour mode, hours count 1..12 with AM/PM flag
MAX_MINUTES, 59, terminal value of the minutes counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
tc_seconds  input  1  one-clock pulse from seconds stage when seconds wraps 59->0
load  input  1  programming strobe, sampled on rising clk
addrs  input  2  register select: 00 seconds (ignored here), 01 minutes, 10 hours, 11 reserved (ignored)
data_in  input  6  load value
q_minutes  output  6  current minutes, 0..59
q_hours  output  5  current hours (0..23 or 1..12)
pm  output  1  12-hour mode only: 1 = PM; tied 0 when HOUR_MODE_24=1
tc_minutes  output  1  one-clock pulse when minutes wraps 59->0
tc_day  output  1  one-clock pulse on day rollover

Behaviour:
- All outputs are registered.
- Reset (reset=0, asynchronous), effective immediately regardless of clk:
  - q_minutes=0, tc_minutes=0, tc_day=0.
  - 24h mode: q_hours=0, pm=0.
  - 12h mode: q_hours=12, pm=0 (12:00 AM).
- Release of reset is synchronous to clk; first count possible on the first rising edge with reset=1.
- Count, on rising clk with tc_seconds=1 and no minutes load:
  - q_minutes<MAX_MINUTES: q_minutes+1.
  - q_minutes==MAX_MINUTES: q_minutes=0, tc_minutes=1 for that cycle, hours step below.
- Hours step (24h): q_hours<23 -> +1; q_hours==23 -> 0 and tc_day=1.
- Hours step (12h):
  - q_hours==11 -> 12 and pm toggles.
  - q_hours==12 -> 1.
  - Else +1.
  - tc_day=1 when the step is 11 PM-hour -> 12 AM (pm 1->0).
- tc_minutes and tc_day are high exactly one clock, in the same cycle the wrapped values appear on q_minutes/q_hours. Both are 0 in all other cycles.
- Latency: tc_seconds sampled at edge N -> updated q_minutes visible after edge N.
- tc_seconds held high for consecutive cycles counts once per cycle; no edge detection.
- Load, on rising clk with load=1:
  - addrs=01: if data_in<=MAX_MINUTES, q_minutes<=data_in; otherwise ignored, no state change.
  - addrs=10, 24h mode: if data_in[4:0]<=23 and data_in[5]==0, q_hours<=data_in[4:0]; else ignored.
  - addrs=10, 12h mode: if 1<=data_in[3:0]<=12 and data_in[4]==0, q_hours<=data_in[3:0] and pm<=data_in[5]; else ignored.
  - addrs=00 or 11: no effect on this block.
  - Loads never generate tc_minutes or tc_day.
- Simultaneous load and tc_seconds:
  - Minutes load wins over minutes count; the carry into hours is suppressed that cycle.
  - Hours load with tc_seconds and q_minutes==59: minutes wraps to 0, tc_minutes=1, hours takes the loaded value, no hours increment, tc_day=0.
  - Invalid load with tc_seconds: load ignored, normal count proceeds.
- Reset asserted mid-operation overrides everything, including a pulse in flight. tc_minutes/tc_day drop to 0 immediately.

Test Plan:
1. Reset low 3 cycles, then release -> q_minutes=0, q_hours=0, tc_minutes=0, tc_day=0; with tc_seconds=0, values hold for 100 cycles.
2. Load minutes=58 (addrs=01, data_in=58), then two tc_seconds pulses -> q_minutes 58->59->0; tc_minutes=1 only on the second pulse; q_hours 0->1.
3. Load hours=23, minutes=59, then one tc_seconds pulse -> q_minutes=0, q_hours=0, tc_minutes=1 and tc_day=1 in the same cycle; both 0 the next cycle.
4. Invalid loads: addrs=01 data_in=60, then addrs=10 data_in=24 -> q_minutes and q_hours unchanged; addrs=00 data_in=5 -> no change.
5. Simultaneous: q_minutes=59, q_hours=5, load addrs=01 data_in=10 with tc_seconds=1 -> q_minutes=10, q_hours=5, tc_minutes=0. Repeat with addrs=10 data_in=7 -> q_minutes=0, q_hours=7, tc_minutes=1.
6. HOUR_MODE_24=0:
   - Reset -> q_hours=12, pm=0.
   - Load hours data_in=6'b101011 (11 PM), minutes=59, one tc_seconds -> q_hours=12, pm=0, tc_day=1.
   - Assert reset asynchronously between clock edges -> outputs return to reset values before the next edge.
